// File: rtl/regfile_scoreboard.sv
// Decode-stage integer register file: two combinational read ports, one write port,
// post-reset zeroing sweep and a per-register pending scoreboard for multi-cycle ops.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32'd32,
    parameter int unsigned ADDR_W   = 32'd5,
    parameter int unsigned ZERO_REG = 32'd1,
    parameter int unsigned BYPASS   = 32'd1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    input  logic              busy_set_en,
    input  logic [ADDR_W-1:0] busy_set_addr,
    output logic              rs1_pending,
    output logic              rs2_pending,
    output logic              init_done
);

    localparam int unsigned       NUM_REGS = 32'd1 << ADDR_W;
    localparam bit                ZR       = (ZERO_REG != 32'd0);
    localparam bit                BP       = (BYPASS != 32'd0);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_0   = {ADDR_W{1'b0}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [ADDR_W-1:0]   idx_r;
    logic [NUM_REGS-1:0] busy_r;
    logic [NUM_REGS-1:0] busy_s;
    logic                init_done_r;
    logic [DATA_W-1:0]   mem_r [NUM_REGS];
    logic                wr_ok_s;
    logic                set_ok_s;

    // Register 0 is never written nor marked pending when hardwired to zero.
    assign wr_ok_s  = (state_r == ST_RUN) && wr_en && !(ZR && (wr_addr == ADDR_0));
    assign set_ok_s = (state_r == ST_RUN) && busy_set_en && !(ZR && (busy_set_addr == ADDR_0));

    assign init_done = init_done_r;

    function automatic logic [DATA_W-1:0] read_data(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] arr_val,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [DATA_W-1:0] wd
    );
        logic [DATA_W-1:0] res;
        if (ZR && (addr == ADDR_0)) begin
            res = {DATA_W{1'b0}};
        end else if (BP && we && (wa == addr)) begin
            res = wd;
        end else begin
            res = arr_val;
        end
        return res;
    endfunction

    function automatic logic read_pending(
        input logic [ADDR_W-1:0]   addr,
        input logic [NUM_REGS-1:0] busy,
        input logic                we,
        input logic [ADDR_W-1:0]   wa
    );
        logic res;
        if (ZR && (addr == ADDR_0)) begin
            res = 1'b0;
        end else begin
            res = busy[addr] && !(we && (wa == addr));
        end
        return res;
    endfunction

    // Sweep FSM next state: leave CLEAR once the last index is written.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (idx_r == LAST_IDX) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_CLEAR;
        endcase
    end

    // Scoreboard next value: a new issue wins over a same-cycle writeback.
    always_comb begin
        busy_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (set_ok_s && (busy_set_addr == ADDR_W'(i))) begin
                busy_s[i] = 1'b1;
            end else if (wr_ok_s && (wr_addr == ADDR_W'(i))) begin
                busy_s[i] = 1'b0;
            end else begin
                busy_s[i] = busy_r[i];
            end
        end
    end

    // Control state: FSM, sweep index, scoreboard and init flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_CLEAR;
            idx_r       <= ADDR_0;
            busy_r      <= {NUM_REGS{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            busy_r      <= busy_s;
            init_done_r <= (state_s == ST_RUN);
            if (state_r == ST_CLEAR) begin
                idx_r <= idx_r + ADDR_W'(1'b1);
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    // Storage array: untouched by the reset edge itself, zeroed by the sweep.
    always_ff @(posedge clk) begin
        if (rst_n && (state_r == ST_CLEAR)) begin
            mem_r[idx_r] <= {DATA_W{1'b0}};
        end else if (rst_n && wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read ports and hazard flags; all forced low until the sweep completes.
    always_comb begin
        op1         = {DATA_W{1'b0}};
        op2         = {DATA_W{1'b0}};
        rs1_pending = 1'b0;
        rs2_pending = 1'b0;
        if (state_r == ST_RUN) begin
            op1         = read_data(rs1_addr, mem_r[rs1_addr], wr_en, wr_addr, wr_data);
            op2         = read_data(rs2_addr, mem_r[rs2_addr], wr_en, wr_addr, wr_data);
            rs1_pending = read_pending(rs1_addr, busy_r, wr_en, wr_addr);
            rs2_pending = read_pending(rs2_addr, busy_r, wr_en, wr_addr);
        end else begin
            op1         = {DATA_W{1'b0}};
            op2         = {DATA_W{1'b0}};
            rs1_pending = 1'b0;
            rs2_pending = 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: default instance (ZERO_REG=1, BYPASS=1) and an alternate instance
// (ZERO_REG=0, BYPASS=0) share stimulus; expected values are queued then compared.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        busy_set_en;
    logic [4:0]  busy_set_addr;
    logic [31:0] op1, op2, alt_op1, alt_op2;
    logic        rs1_pending, rs2_pending, alt_rs1_pending, alt_rs2_pending;
    logic        init_done, alt_init_done;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [31:0] m_main [32];
    logic [31:0] m_alt [32];

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .op1(op1), .op2(op2),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rs1_pending(rs1_pending), .rs2_pending(rs2_pending), .init_done(init_done)
    );

    regfile_scoreboard #(.ZERO_REG(32'd0), .BYPASS(32'd0)) dut_alt (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .op1(alt_op1), .op2(alt_op2),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr),
        .rs1_pending(alt_rs1_pending), .rs2_pending(alt_rs2_pending), .init_done(alt_init_done)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE0000;
        busy_set_en = 1'b1; busy_set_addr = 5'd5; rs1_addr = 5'd5; rs2_addr = 5'd0;
        tick();
        tick();
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, init_done} !== e) begin errors++; $display("FAIL reset_init_done got=%0h exp=%0h", init_done, e); end
        e = exp_q.pop_front(); checks++;
        if (op1 !== e) begin errors++; $display("FAIL reset_op1 got=%h exp=%h", op1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL reset_pending got=%0h exp=%0h", rs1_pending, e); end
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 32) begin wr_en = 1'b0; busy_set_en = 1'b0; end
            exp_q.push_back((k == 32) ? 32'd1 : 32'd0);
            exp_q.push_back(32'd0);
            #1;
            e = exp_q.pop_front(); checks++;
            if ({31'd0, init_done} !== e) begin errors++; $display("FAIL sweep_init_done edge=%0d got=%0h exp=%0h", k, init_done, e); end
            e = exp_q.pop_front(); checks++;
            if (op1 !== e) begin errors++; $display("FAIL sweep_op1 edge=%0d got=%h exp=%h", k, op1, e); end
        end
        exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, alt_init_done} !== e) begin errors++; $display("FAIL alt_init_done got=%0h exp=%0h", alt_init_done, e); end
        for (int i = 0; i < 32; i++) begin
            tick();
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
            exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
            #1;
            e = exp_q.pop_front(); checks++;
            if (op1 !== e) begin errors++; $display("FAIL clear_op1 x%0d got=%h exp=%h", i, op1, e); end
            e = exp_q.pop_front(); checks++;
            if (op2 !== e) begin errors++; $display("FAIL clear_op2 x%0d got=%h exp=%h", 31 - i, op2, e); end
            e = exp_q.pop_front(); checks++;
            if (alt_op1 !== e) begin errors++; $display("FAIL clear_alt_op1 x%0d got=%h exp=%h", i, alt_op1, e); end
        end
        tick();
        rs1_addr = 5'd5;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL clear_set_ignored got=%0h exp=%0h", rs1_pending, e); end
    endtask

    task automatic test_bypass();
        tick();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs1_addr = 5'd5;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (op1 !== e) begin errors++; $display("FAIL bypass_op1 got=%h exp=%h", op1, e); end
        e = exp_q.pop_front(); checks++;
        if (alt_op1 !== e) begin errors++; $display("FAIL nobypass_op1 got=%h exp=%h", alt_op1, e); end
        tick();
        wr_en = 1'b0;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        #1;
        e = exp_q.pop_front(); checks++;
        if (op1 !== e) begin errors++; $display("FAIL bypass_next_op1 got=%h exp=%h", op1, e); end
        e = exp_q.pop_front(); checks++;
        if (alt_op1 !== e) begin errors++; $display("FAIL nobypass_next_op1 got=%h exp=%h", alt_op1, e); end
    endtask

    task automatic test_zero_reg();
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        busy_set_en = 1'b1; busy_set_addr = 5'd0; rs1_addr = 5'd0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (op1 !== e) begin errors++; $display("FAIL zero_op1_same got=%h exp=%h", op1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL zero_pending_same got=%0h exp=%0h", rs1_pending, e); end
        tick();
        wr_en = 1'b0; busy_set_en = 1'b0;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        exp_q.push_back(32'h12345678); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (op1 !== e) begin errors++; $display("FAIL zero_op1_next got=%h exp=%h", op1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL zero_pending_next got=%0h exp=%0h", rs1_pending, e); end
        e = exp_q.pop_front(); checks++;
        if (alt_op1 !== e) begin errors++; $display("FAIL alt_x0_op1 got=%h exp=%h", alt_op1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, alt_rs1_pending} !== e) begin errors++; $display("FAIL alt_x0_pending got=%0h exp=%0h", alt_rs1_pending, e); end
        tick();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd0;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_scoreboard();
        busy_set_en = 1'b1; busy_set_addr = 5'd7; rs2_addr = 5'd7;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs2_pending} !== e) begin errors++; $display("FAIL sb_pending_issue got=%0h exp=%0h", rs2_pending, e); end
        tick();
        busy_set_en = 1'b0;
        exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs2_pending} !== e) begin errors++; $display("FAIL sb_pending_set got=%0h exp=%0h", rs2_pending, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, alt_rs2_pending} !== e) begin errors++; $display("FAIL sb_alt_pending_set got=%0h exp=%0h", alt_rs2_pending, e); end
        tick();
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
        exp_q.push_back(32'd0); exp_q.push_back(32'hA5); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs2_pending} !== e) begin errors++; $display("FAIL sb_pending_wb got=%0h exp=%0h", rs2_pending, e); end
        e = exp_q.pop_front(); checks++;
        if (op2 !== e) begin errors++; $display("FAIL sb_op2_wb got=%h exp=%h", op2, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, alt_rs2_pending} !== e) begin errors++; $display("FAIL sb_alt_pending_wb got=%0h exp=%0h", alt_rs2_pending, e); end
        e = exp_q.pop_front(); checks++;
        if (alt_op2 !== e) begin errors++; $display("FAIL sb_alt_op2_wb got=%h exp=%h", alt_op2, e); end
        for (int k = 0; k < 2; k++) begin
            tick();
            wr_en = 1'b0;
            exp_q.push_back(32'd0); exp_q.push_back(32'hA5);
            #1;
            e = exp_q.pop_front(); checks++;
            if ({31'd0, rs2_pending} !== e) begin errors++; $display("FAIL sb_pending_after got=%0h exp=%0h", rs2_pending, e); end
            e = exp_q.pop_front(); checks++;
            if (op2 !== e) begin errors++; $display("FAIL sb_op2_after got=%h exp=%h", op2, e); end
        end
    endtask

    task automatic test_set_write();
        tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
        busy_set_en = 1'b1; busy_set_addr = 5'd9; rs1_addr = 5'd9;
        tick();
        wr_en = 1'b0; busy_set_en = 1'b0;
        exp_q.push_back(32'h1); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
        #1;
        e = exp_q.pop_front(); checks++;
        if (op1 !== e) begin errors++; $display("FAIL setwr_op1 got=%h exp=%h", op1, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL setwr_pending got=%0h exp=%0h", rs1_pending, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, alt_rs1_pending} !== e) begin errors++; $display("FAIL setwr_alt_pending got=%0h exp=%0h", alt_rs1_pending, e); end
        tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1;
        tick();
        wr_en = 1'b0;
        exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL setwr_cleared got=%0h exp=%0h", rs1_pending, e); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  wa, ra;
        logic [31:0] wd;
        for (int i = 0; i < 32; i++) begin m_main[i] = 32'd0; m_alt[i] = 32'd0; end
        m_main[5] = 32'hDEADBEEF; m_alt[5] = 32'hDEADBEEF;
        m_main[7] = 32'hA5;       m_alt[7] = 32'hA5;
        m_main[9] = 32'h1;        m_alt[9] = 32'h1;
        for (int k = 0; k < 24; k++) begin
            tick();
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            ra = (k % 3 == 0) ? wa : 5'($urandom_range(0, 31));
            if (k == 6) begin wa = 5'd0; ra = 5'd0; end
            wr_en = 1'b1; wr_addr = wa; wr_data = wd; rs1_addr = ra;
            exp_q.push_back((ra == 5'd0) ? 32'd0 : ((ra == wa) ? wd : m_main[ra]));
            exp_q.push_back(m_alt[ra]);
            #1;
            e = exp_q.pop_front(); checks++;
            if (op1 !== e) begin errors++; $display("FAIL b2b_op1 k=%0d x%0d got=%h exp=%h", k, ra, op1, e); end
            e = exp_q.pop_front(); checks++;
            if (alt_op1 !== e) begin errors++; $display("FAIL b2b_alt_op1 k=%0d x%0d got=%h exp=%h", k, ra, alt_op1, e); end
            if (wa != 5'd0) m_main[wa] = wd;
            m_alt[wa] = wd;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFF;
        busy_set_en = 1'b1; busy_set_addr = 5'd3; rs1_addr = 5'd3; rs2_addr = 5'd4;
        tick();
        wr_en = 1'b0; busy_set_en = 1'b0;
        exp_q.push_back(32'd1); exp_q.push_back(32'hFF);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL mid_pre_pending got=%0h exp=%0h", rs1_pending, e); end
        e = exp_q.pop_front(); checks++;
        if (op2 !== e) begin errors++; $display("FAIL mid_pre_op2 got=%h exp=%h", op2, e); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL mid_rst_pending got=%0h exp=%0h", rs1_pending, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, init_done} !== e) begin errors++; $display("FAIL mid_rst_init_done got=%0h exp=%0h", init_done, e); end
        e = exp_q.pop_front(); checks++;
        if (op2 !== e) begin errors++; $display("FAIL mid_rst_op2 got=%h exp=%h", op2, e); end
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k >= 31) begin
                exp_q.push_back((k == 32) ? 32'd1 : 32'd0);
                #1;
                e = exp_q.pop_front(); checks++;
                if ({31'd0, init_done} !== e) begin errors++; $display("FAIL mid_init_done edge=%0d got=%0h exp=%0h", k, init_done, e); end
            end
        end
        exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (op2 !== e) begin errors++; $display("FAIL mid_x4_cleared got=%h exp=%h", op2, e); end
        e = exp_q.pop_front(); checks++;
        if (alt_op2 !== e) begin errors++; $display("FAIL mid_alt_x4_cleared got=%h exp=%h", alt_op2, e); end
        e = exp_q.pop_front(); checks++;
        if ({31'd0, rs1_pending} !== e) begin errors++; $display("FAIL mid_x3_pending got=%0h exp=%0h", rs1_pending, e); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_set_write();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the RV32IM pipeline's decode stage, with write-to-read bypass, a post-reset clearing sweep, and a per-register pending scoreboard. The scoreboard lets the hazard unit stall on destinations still owned by multi-cycle MUL/DIV operations. It replaces the fixed 32x32 two-read/one-write array. Reads are combinational, writes are synchronous, and all state is deterministic after reset.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 hardwired to zero (never written, never pending); 0 = register 0 is ordinary
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return array contents only

- clk  input  1  single clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- wr_en  input  1  writeback enable
- wr_addr  input  ADDR_W  writeback destination
- wr_data  input  DATA_W  writeback data
- rs1_addr  input  ADDR_W  read port 1 address
- rs2_addr  input  ADDR_W  read port 2 address
- op1  output  DATA_W  read port 1 data (combinational)
- op2  output  DATA_W  read port 2 data (combinational)
- busy_set_en  input  1  mark a destination pending (multi-cycle op issued)
- busy_set_addr  input  ADDR_W  destination to mark pending
- rs1_pending  output  1  rs1 register awaiting writeback
- rs2_pending  output  1  rs2 register awaiting writeback
- init_done  output  1  clearing sweep complete; block usable

## Operation
- FSM with two states: CLEAR and RUN.
- Reset (rst_n=0 at a rising edge):
  - state <= CLEAR, sweep index <= 0, all busy bits <= 0.
  - Array contents are not touched on that edge.
- CLEAR:
  - Each rising edge with rst_n=1 writes 0 to array[index] and increments index.
  - On the edge that writes index NUM_REGS-1: state <= RUN and init_done <= 1.
  - wr_en and busy_set_en are ignored.
  - op1/op2 = 0, rs1_pending/rs2_pending = 0, init_done = 0.
- RUN, write:
  - wr_en=1 writes wr_data to array[wr_addr] at the edge and clears busy[wr_addr].
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- RUN, scoreboard set:
  - busy_set_en=1 sets busy[busy_set_addr] at the edge.
  - Ignored for address 0 when ZERO_REG=1.
- Simultaneous set and write to the same address: the write updates data, and the busy bit ends SET (the new issue wins).
- Read data for each port independently, first matching rule applies:
  - If ZERO_REG=1 and addr=0: 0.
  - Else if BYPASS=1, wr_en=1, and wr_addr=addr: wr_data.
  - Else array[addr].
- Pending for each port = busy[addr] AND NOT (wr_en AND wr_addr=addr). The same-cycle writeback resolves the hazard. Forced to 0 for addr 0 when ZERO_REG=1.
- Reset mid-sweep or mid-run restarts the sweep from index 0 and clears all busy bits.

## Timing
- Reset values: init_done=0, all busy=0, op1=op2=0, rs1_pending=rs2_pending=0 throughout CLEAR.
- init_done rises after exactly NUM_REGS rising edges with rst_n=1 (32 for defaults).
- Read latency 0 (combinational from addresses, write port and array).
- Write latency 1: the array is visible without bypass from the cycle after the write edge.
- Scoreboard set latency 1: pending asserts in the cycle after busy_set_en.
- Scoreboard clear: pending deasserts combinationally in the writeback cycle.
- No handshake back-pressure. Callers must gate issue on init_done.

## Test plan
- Reset then sweep: hold rst_n=0 for 2 cycles, release, read all addresses:
  - init_done=0 for edges 1–31 and 1 after edge 32.
  - Every register reads 0x00000000.
- Write/read with bypass: write x5=0xDEADBEEF with rs1_addr=5 in the same cycle:
  - op1=0xDEADBEEF in that cycle (BYPASS=1).
  - With BYPASS=0: op1=0 in that cycle and 0xDEADBEEF on the next.
- Zero register: wr_en=1, wr_addr=0, wr_data=0x12345678, busy_set on addr 0:
  - op1 with rs1_addr=0 stays 0.
  - rs1_pending stays 0.
  - With ZERO_REG=0, op1 reads 0x12345678 next cycle.
- Scoreboard lifecycle:
  - busy_set x7, then rs2_addr=7 → rs2_pending=1 next cycle.
  - Writeback x7=0xA5 → rs2_pending=0 and op2=0xA5 in the same cycle; busy stays clear afterward.
- Simultaneous set and write on x9 (data 0x1): x9 holds 0x1 and rs1_pending=1 on the following cycle.
- Reset mid-run with x3 busy and x4=0xFF: rst_n=0 for one edge →
  - pending=0.
  - init_done=0.
  - After 32 more edges, x4 reads 0.
